// File: rtl/uart_rx_checker_pkg.sv
// Shared types for the UART receive-side checker: FSM encoding and a small
// state-classification helper used by the top level.
package uart_rx_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } chk_state_e;

    // A run is in progress (timeout counting, busy asserted) in WAIT and ACK.
    function automatic logic is_active(input chk_state_e st);
        return (st == ST_WAIT) || (st == ST_ACK);
    endfunction

endpackage

// File: rtl/uart_rx_checker_mem.sv
// Expected-sequence and capture storage for the UART checker.
// Both arrays write synchronously and read combinationally; neither is reset.
module uart_rx_checker_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  exp_wr_en,
    input  logic [IDX_W-1:0]      exp_wr_addr,
    input  logic [DATA_WIDTH-1:0] exp_wr_data,
    input  logic [IDX_W-1:0]      exp_rd_addr,
    output logic [DATA_WIDTH-1:0] exp_rd_data,
    input  logic                  cap_wr_en,
    input  logic [IDX_W-1:0]      cap_wr_addr,
    input  logic [DATA_WIDTH-1:0] cap_wr_data,
    input  logic [IDX_W-1:0]      cap_rd_addr,
    output logic [DATA_WIDTH-1:0] cap_rd_data
);

    logic [DATA_WIDTH-1:0] exp_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] cap_mem_r [DEPTH];

    // Expected-sequence write port; contents survive reset and re-arming.
    always_ff @(posedge clk) begin
        if (exp_wr_en) begin
            exp_mem_r[exp_wr_addr] <= exp_wr_data;
        end
    end

    // Capture write port, driven by each consumed UART word.
    always_ff @(posedge clk) begin
        if (cap_wr_en) begin
            cap_mem_r[cap_wr_addr] <= cap_wr_data;
        end
    end

    assign exp_rd_data = exp_mem_r[exp_rd_addr];
    assign cap_rd_data = cap_mem_r[cap_rd_addr];

endmodule

// File: rtl/uart_rx_checker.sv
// Receive-side checker: consumes UART words one handshake at a time, captures
// them and compares against a preloaded sequence, with a global run timeout.
module uart_rx_checker
    import uart_rx_checker_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 150000,
    parameter int STOP_ON_ERROR  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   num_expected,
    input  logic                         exp_wr_en,
    input  logic [$clog2(DEPTH)-1:0]     exp_wr_addr,
    input  logic [DATA_WIDTH-1:0]        exp_wr_data,
    input  logic [DATA_WIDTH-1:0]        data_out,
    input  logic                         data_out_valid,
    output logic                         data_out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [$clog2(DEPTH+1)-1:0]   match_count,
    output logic [$clog2(DEPTH+1)-1:0]   mismatch_count,
    output logic [$clog2(DEPTH)-1:0]     first_err_idx,
    output logic [DATA_WIDTH-1:0]        first_err_data,
    output logic                         err_seen,
    input  logic [$clog2(DEPTH)-1:0]     cap_rd_addr,
    output logic [DATA_WIDTH-1:0]        cap_rd_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic             STOP_C   = (STOP_ON_ERROR != 0);

    chk_state_e            state_r;
    chk_state_e            state_s;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      idx_r;
    logic [TMO_W-1:0]      tmo_r;
    logic [CNT_W-1:0]      match_r;
    logic [CNT_W-1:0]      mismatch_r;
    logic [IDX_W-1:0]      first_err_idx_r;
    logic [DATA_WIDTH-1:0] first_err_data_r;
    logic                  err_seen_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  pass_r;
    logic                  timeout_r;

    logic [CNT_W-1:0]      count_s;
    logic [DATA_WIDTH-1:0] exp_data_s;
    logic                  start_ok_s;
    logic                  tmo_hit_s;
    logic                  take_s;
    logic                  last_s;

    uart_rx_checker_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk         (clk),
        .exp_wr_en   (exp_wr_en && !is_active(state_r)),
        .exp_wr_addr (exp_wr_addr),
        .exp_wr_data (exp_wr_data),
        .exp_rd_addr (idx_r[IDX_W-1:0]),
        .exp_rd_data (exp_data_s),
        .cap_wr_en   (take_s),
        .cap_wr_addr (idx_r[IDX_W-1:0]),
        .cap_wr_data (data_out),
        .cap_rd_addr (cap_rd_addr),
        .cap_rd_data (cap_rd_data)
    );

    // Run-control decodes; timeout wins over a same-cycle valid word.
    always_comb begin
        start_ok_s = start && !is_active(state_r);
        count_s    = (num_expected > DEPTH_C) ? DEPTH_C : num_expected;
        tmo_hit_s  = is_active(state_r) && (tmo_r == TMO_LAST);
        take_s     = (state_r == ST_WAIT) && data_out_valid && !tmo_hit_s;
        last_s     = ((idx_r + CNT_W'(1)) == count_r);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_s = (count_s == CNT_W'(0)) ? ST_DONE : ST_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT: begin
                if (tmo_hit_s) begin
                    state_s = ST_DONE;
                end else if (data_out_valid) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                if (tmo_hit_s || last_s || (STOP_C && err_seen_r)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status outputs are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_ACK);
            busy_r  <= is_active(state_s);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Run bookkeeping: counters, index, first-error record, verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r          <= '0;
            idx_r            <= '0;
            tmo_r            <= '0;
            match_r          <= '0;
            mismatch_r       <= '0;
            first_err_idx_r  <= '0;
            first_err_data_r <= '0;
            err_seen_r       <= 1'b0;
            pass_r           <= 1'b0;
            timeout_r        <= 1'b0;
        end else if (start_ok_s) begin
            count_r          <= count_s;
            idx_r            <= '0;
            tmo_r            <= '0;
            match_r          <= '0;
            mismatch_r       <= '0;
            first_err_idx_r  <= '0;
            first_err_data_r <= '0;
            err_seen_r       <= 1'b0;
            timeout_r        <= 1'b0;
            pass_r           <= (count_s == CNT_W'(0));
        end else begin
            if (is_active(state_r)) begin
                tmo_r <= tmo_r + TMO_W'(1);
            end
            if (take_s) begin
                if (data_out == exp_data_s) begin
                    match_r <= match_r + CNT_W'(1);
                end else begin
                    mismatch_r <= mismatch_r + CNT_W'(1);
                    if (!err_seen_r) begin
                        first_err_idx_r  <= idx_r[IDX_W-1:0];
                        first_err_data_r <= data_out;
                        err_seen_r       <= 1'b1;
                    end
                end
            end
            if (state_r == ST_ACK) begin
                idx_r <= idx_r + CNT_W'(1);
            end
            if (tmo_hit_s) begin
                timeout_r <= 1'b1;
                pass_r    <= 1'b0;
            end else if ((state_r == ST_ACK) && (state_s == ST_DONE)) begin
                pass_r <= (match_r == count_r);
            end
        end
    end

    assign data_out_ready = ready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign timeout        = timeout_r;
    assign match_count    = match_r;
    assign mismatch_count = mismatch_r;
    assign first_err_idx  = first_err_idx_r;
    assign first_err_data = first_err_data_r;
    assign err_seen       = err_seen_r;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Directed bench for uart_rx_checker: one instance keeps going on mismatch,
// a second stops on the first error; both use a 1000-cycle timeout.
module tb_uart_rx_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [4:0] num_expected;
    logic       exp_wr_en;
    logic [3:0] exp_wr_addr;
    logic [7:0] exp_wr_data;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [3:0] cap_rd_addr;

    logic       rdy0, busy0, done0, pass0, tmo0, err0;
    logic [4:0] mc0, mmc0;
    logic [3:0] fei0;
    logic [7:0] fed0, cap0;
    logic       rdy1, busy1, done1, pass1, tmo1, err1;
    logic [4:0] mc1, mmc1;
    logic [3:0] fei1;
    logic [7:0] fed1, cap1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rp0   = 0;

    uart_rx_checker #(.DATA_WIDTH(8), .DEPTH(16), .TIMEOUT_CYCLES(1000), .STOP_ON_ERROR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .num_expected(num_expected),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(rdy0),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0),
        .match_count(mc0), .mismatch_count(mmc0), .first_err_idx(fei0),
        .first_err_data(fed0), .err_seen(err0), .cap_rd_addr(cap_rd_addr), .cap_rd_data(cap0)
    );

    uart_rx_checker #(.DATA_WIDTH(8), .DEPTH(16), .TIMEOUT_CYCLES(1000), .STOP_ON_ERROR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .num_expected(num_expected),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(rdy1),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(tmo1),
        .match_count(mc1), .mismatch_count(mmc1), .first_err_idx(fei1),
        .first_err_data(fed1), .err_seen(err1), .cap_rd_addr(cap_rd_addr), .cap_rd_data(cap1)
    );

    always #5 clk = ~clk;

    // Free-running cycle count and ready-pulse count for instance 0.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdy0) rp0 <= rp0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int sel, input logic [4:0] n);
        @(negedge clk);
        num_expected = n;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Offer one word; got=1 if the selected instance acknowledged it in time.
    task automatic send(input int sel, input logic [7:0] d, output bit got);
        logic r;
        @(negedge clk);
        data_out       = d;
        data_out_valid = 1'b1;
        got            = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            r = (sel == 0) ? rdy0 : rdy1;
            if (r) got = 1'b1;
        end
        data_out_valid = 1'b0;
        if (got) begin
            @(negedge clk);
            r = (sel == 0) ? rdy0 : rdy1;
            check("ready_one_cycle", 32'(r), 32'd0);
        end
    endtask

    task automatic send_ok(input int sel, input logic [7:0] d, input string tag);
        bit g;
        send(sel, d, g);
        check(tag, 32'(g), 32'd1);
    endtask

    initial begin
        bit         g;
        int         base, c0;
        logic [7:0] seq [3];
        seq[0] = 8'h64; seq[1] = 8'h58; seq[2] = 8'h2C;

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; num_expected = 5'd0;
        exp_wr_en = 1'b0; exp_wr_addr = 4'd0; exp_wr_data = 8'd0;
        data_out = 8'd0; data_out_valid = 1'b0; cap_rd_addr = 4'd0;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(rdy0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_match", 32'(mc0), 32'd0);
        check("rst_err_seen", 32'(err0), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_wr_en = 1'b1; exp_wr_addr = 4'(i); exp_wr_data = seq[i];
        end
        @(negedge clk);
        exp_wr_en = 1'b0;

        // Clean run of three matching words, with a start while busy
        base = rp0;
        pulse_start(0, 5'd3);
        check("busy_after_start", 32'(busy0), 32'd1);
        send_ok(0, 8'h64, "t1_w0");
        pulse_start(0, 5'd1);
        send_ok(0, 8'h58, "t1_w1");
        send_ok(0, 8'h2C, "t1_w2");
        check("t1_done", 32'(done0), 32'd1);
        check("t1_busy", 32'(busy0), 32'd0);
        check("t1_pass", 32'(pass0), 32'd1);
        check("t1_match", 32'(mc0), 32'd3);
        check("t1_mismatch", 32'(mmc0), 32'd0);
        check("t1_ready_pulses", 32'(rp0 - base), 32'd3);
        cap_rd_addr = 4'd1;
        #1;
        check("t1_cap1", 32'(cap0), 32'h58);

        // Mismatch on word 1, keep receiving
        pulse_start(0, 5'd3);
        check("t2_done_cleared", 32'(done0), 32'd0);
        send_ok(0, 8'h64, "t2_w0");
        send_ok(0, 8'h59, "t2_w1");
        send_ok(0, 8'h2C, "t2_w2");
        check("t2_done", 32'(done0), 32'd1);
        check("t2_pass", 32'(pass0), 32'd0);
        check("t2_match", 32'(mc0), 32'd2);
        check("t2_mismatch", 32'(mmc0), 32'd1);
        check("t2_first_idx", 32'(fei0), 32'd1);
        check("t2_first_data", 32'(fed0), 32'h59);
        check("t2_err_seen", 32'(err0), 32'd1);
        #1;
        check("t2_cap1", 32'(cap0), 32'h59);

        // Stop-on-error instance finishes after the bad word
        pulse_start(1, 5'd3);
        send_ok(1, 8'h64, "t3_w0");
        send_ok(1, 8'h59, "t3_w1");
        check("t3_done", 32'(done1), 32'd1);
        send(1, 8'h2C, g);
        check("t3_w2_unconsumed", 32'(g), 32'd0);
        check("t3_match", 32'(mc1), 32'd1);
        check("t3_mismatch", 32'(mmc1), 32'd1);
        check("t3_pass", 32'(pass1), 32'd0);

        // Timeout with only one of three words sent
        pulse_start(0, 5'd3);
        c0 = cyc;
        send_ok(0, 8'h64, "t4_w0");
        for (int i = 0; i < 1500 && !done0; i++) @(negedge clk);
        check("t4_done", 32'(done0), 32'd1);
        check("t4_latency", 32'(cyc - c0), 32'd1000);
        check("t4_timeout", 32'(tmo0), 32'd1);
        check("t4_pass", 32'(pass0), 32'd0);
        check("t4_match", 32'(mc0), 32'd1);

        // Zero-length run completes one cycle after start
        @(negedge clk);
        num_expected = 5'd0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("t5_done", 32'(done0), 32'd1);
        check("t5_pass", 32'(pass0), 32'd1);
        check("t5_busy", 32'(busy0), 32'd0);
        check("t5_timeout", 32'(tmo0), 32'd0);

        // Reset in the middle of a run
        pulse_start(0, 5'd3);
        send_ok(0, 8'h64, "t6_w0");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy0), 32'd0);
        check("t6_done", 32'(done0), 32'd0);
        check("t6_match", 32'(mc0), 32'd0);
        check("t6_ready", 32'(rdy0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
